// File: rtl/cpu_seq_if.sv
// Sequencer bus bundle: unified memory port plus the instruction/strobe link to the datapath.
// master = sequencer side, slave = memory/datapath side.
interface cpu_seq_if #(
   parameter int unsigned BUSW  = 32,
   parameter int unsigned MINDW = 12,
   parameter int unsigned PSRW  = 5
);
   logic [MINDW-1:0] mem_addr;
   logic             mem_ren;
   logic             mem_wen;
   logic [BUSW-1:0]  mem_rdata;
   logic [PSRW-1:0]  psr;
   logic [31:0]      ireg;
   logic             exec_stb;
   logic             wb_stb;

   modport master (
      output mem_addr, mem_ren, mem_wen, ireg, exec_stb, wb_stb,
      input  mem_rdata, psr
   );

   modport slave (
      input  mem_addr, mem_ren, mem_wen, ireg, exec_stb, wb_stb,
      output mem_rdata, psr
   );
endinterface

// File: rtl/cpu_seq.sv
// Fetch/decode sequencer: owns PC and IR, fetches from memory and steps the datapath.
// Define CPU_SEQ_ICOUNT_EN to add the retired-instruction counter output o_icount.
module cpu_seq #(
   parameter int unsigned BUSW  = 32,
   parameter int unsigned MINDW = 12,
   parameter int unsigned PSRW  = 5
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_run,
   cpu_seq_if.master        bus,
   output logic [MINDW-1:0] o_pc,
   output logic             o_halted
`ifdef CPU_SEQ_ICOUNT_EN
   ,
   output logic [31:0]      o_icount
`endif
);

   typedef enum logic [2:0] {
      StIdle, StFetch, StLoad, StDecode, StExec, StMem, StWb
   } state_e;

   localparam logic [3:0] OpLd  = 4'd1;
   localparam logic [3:0] OpStr = 4'd2;
   localparam logic [3:0] OpBra = 4'd3;
   localparam logic [3:0] OpXor = 4'd4;
   localparam logic [3:0] OpAdd = 4'd5;
   localparam logic [3:0] OpRot = 4'd6;
   localparam logic [3:0] OpShf = 4'd7;
   localparam logic [3:0] OpHlt = 4'd8;
   localparam logic [3:0] OpCmp = 4'd9;

   state_e           r_state;
   logic [MINDW-1:0] r_pc;
   logic [31:0]      r_ireg;
   logic [MINDW-1:0] r_mem_addr;
   logic             r_mem_ren;
   logic             r_mem_wen;
   logic             r_exec_stb;
   logic             r_wb_stb;
   logic             r_halted;
`ifdef CPU_SEQ_ICOUNT_EN
   logic [31:0]      r_icount;
`endif

   state_e           w_state_d;
   logic [MINDW-1:0] w_pc_d;
   logic [31:0]      w_ireg_d;
   logic [BUSW-1:0]  w_rdata;
   logic [PSRW-1:0]  w_cc;
   logic [3:0]       w_op;
   logic [3:0]       w_op_d;
   logic [MINDW-1:0] w_addr_f;
   logic             w_taken;
   logic             w_retire;

   assign w_rdata  = bus.mem_rdata;
   assign w_op     = r_ireg[31:28];
   assign w_cc     = PSRW'(r_ireg[27:23]);
   assign w_addr_f = r_ireg[MINDW-1:0];
   assign w_taken  = (w_cc == '0) || (|(w_cc & bus.psr));
   assign w_op_d   = w_ireg_d[31:28];
   assign w_retire = (r_state inside {StDecode, StExec, StMem, StWb}) &&
                     (w_state_d inside {StFetch, StIdle});

   always_comb begin
      w_state_d = r_state;
      w_pc_d    = r_pc;
      w_ireg_d  = r_ireg;
      unique case (r_state)
         StIdle:   if (i_run) w_state_d = StFetch;
         StFetch:  w_state_d = StLoad;
         StLoad: begin
            w_ireg_d  = w_rdata[31:0];
            w_pc_d    = r_pc + MINDW'(1);
            w_state_d = StDecode;
         end
         StDecode: begin
            case (w_op)
               OpHlt: w_state_d = StIdle;
               OpBra: begin
                  if (w_taken) w_pc_d = w_addr_f;
                  w_state_d = StFetch;
               end
               OpLd:  w_state_d = StMem;
               OpStr, OpXor, OpAdd, OpRot, OpShf, OpCmp: w_state_d = StExec;
               default: w_state_d = StFetch;
            endcase
         end
         StExec: begin
            case (w_op)
               OpStr:   w_state_d = StMem;
               OpCmp:   w_state_d = StFetch;
               default: w_state_d = StWb;
            endcase
         end
         StMem:    w_state_d = (w_op == OpLd) ? StWb : StFetch;
         StWb:     w_state_d = StFetch;
         default:  w_state_d = StIdle;
      endcase
   end

   // Outputs are decoded from the next state so each is a plain register (Moore, no input paths).
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= StIdle;
         r_pc       <= '0;
         r_ireg     <= '0;
         r_mem_addr <= '0;
         r_mem_ren  <= 1'b0;
         r_mem_wen  <= 1'b0;
         r_exec_stb <= 1'b0;
         r_wb_stb   <= 1'b0;
         r_halted   <= 1'b1;
`ifdef CPU_SEQ_ICOUNT_EN
         r_icount   <= '0;
`endif
      end else begin
         r_state    <= w_state_d;
         r_pc       <= w_pc_d;
         r_ireg     <= w_ireg_d;
         r_mem_addr <= (w_state_d == StMem) ? w_ireg_d[MINDW-1:0] : w_pc_d;
         r_mem_ren  <= (w_state_d == StFetch) || ((w_state_d == StMem) && (w_op_d == OpLd));
         r_mem_wen  <= (w_state_d == StMem) && (w_op_d == OpStr);
         r_exec_stb <= (w_state_d == StExec);
         r_wb_stb   <= (w_state_d == StWb);
         r_halted   <= (w_state_d == StIdle);
`ifdef CPU_SEQ_ICOUNT_EN
         if (w_retire) r_icount <= r_icount + 32'd1;
`endif
      end
   end

   assign bus.mem_addr = r_mem_addr;
   assign bus.mem_ren  = r_mem_ren;
   assign bus.mem_wen  = r_mem_wen;
   assign bus.ireg     = r_ireg;
   assign bus.exec_stb = r_exec_stb;
   assign bus.wb_stb   = r_wb_stb;
   assign o_pc         = r_pc;
   assign o_halted     = r_halted;
`ifdef CPU_SEQ_ICOUNT_EN
   assign o_icount     = r_icount;
`else
   logic w_unused;
   assign w_unused = w_retire;
`endif

endmodule

// File: doc/cpu_seq.md
# cpu_seq

Fetch/decode sequencer for the 32-bit teaching CPU datapath. It owns the program counter and instruction register. It fetches each instruction from memory and steps the datapath through execute, memory-access and write-back phases with one-cycle strobes. It sits between the unified program/data memory and the `cpu` execution datapath and is the only block that drives the memory address bus.

## Interface

Parameters:
- `BUSW`, 32, memory data bus width
- `MINDW`, 12, memory address width (PC width)
- `PSRW`, 5, PSR width; bits {zero, negative, even, parity, carry} = [4:0]

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  synchronous, active-high reset
- `run`  in  1  start/resume; sampled only in IDLE
- `mem_rdata`  in  BUSW  memory read data, valid one cycle after `mem_ren`
- `psr`  in  PSRW  current PSR from datapath
- `mem_addr`  out  MINDW  memory address
- `mem_ren`  out  1  memory read enable
- `mem_wen`  out  1  memory write enable (write data driven by datapath)
- `ireg`  out  32  instruction register, to datapath
- `exec_stb`  out  1  one-cycle pulse: datapath executes `ireg`
- `wb_stb`  out  1  one-cycle pulse: datapath writes result to destination
- `pc`  out  MINDW  program counter
- `halted`  out  1  high in IDLE

## Operation

- Instruction fields: opcode = `ireg[31:28]`; branch condition `cc` = `ireg[27:23]`; address field = `ireg[MINDW-1:0]`.
- Opcodes: NOP 0, LD 1, STR 2, BRA 3, XOR 4, ADD 5, ROT 6, SHF 7, HLT 8, CMP 9. Opcodes 10–15 decode as NOP.
- States: IDLE, FETCH, LOAD, DECODE, EXEC, MEM, WB.
- IDLE: `halted`=1; `run`=1 -> FETCH.
- FETCH: `mem_addr`=`pc`, `mem_ren`=1 -> LOAD.
- LOAD: `ireg`<=`mem_rdata`; `pc`<=`pc`+1, modulo 2^MINDW -> DECODE.
- DECODE, by opcode:
  - NOP/illegal -> FETCH.
  - HLT -> IDLE.
  - BRA: taken if `cc`==0 or |(`cc` & `psr`); if taken, `pc`<=address field. -> FETCH.
  - LD -> MEM.
  - STR, XOR, ADD, ROT, SHF, CMP -> EXEC.
- EXEC: `exec_stb`=1. Next: STR -> MEM; CMP -> FETCH (PSR-only); others -> WB.
- MEM: `mem_addr`=address field. LD: `mem_ren`=1 -> WB. STR: `mem_wen`=1 -> FETCH.
- WB: `wb_stb`=1 -> FETCH. For LD, `mem_rdata` is valid during WB.
- `mem_addr` outside FETCH/MEM equals `pc`. `mem_ren`, `mem_wen`, `exec_stb` and `wb_stb` are never high together.
- `run` asserted outside IDLE is ignored.

## Timing

- Outputs decode from registered state only (Moore); no input-to-output combinational path.
- Reset values: state IDLE, `pc`=0, `ireg`=0, `halted`=1, all strobes/enables 0, `mem_addr`=0.
- Reset mid-instruction aborts it: strobes low in the cycle after `reset`. A partially executed STR or LD is not retried.
- Cycles per instruction, FETCH to next FETCH:
  - NOP/illegal/BRA: 3
  - CMP: 4
  - LD, STR, XOR, ADD, ROT, SHF: 5
  - HLT: 3 to reach IDLE
- IDLE with `run`=1 at edge N: FETCH in cycle N+1.
- BRA condition uses `psr` sampled in DECODE, so the PSR from the previous instruction's EXEC is visible.
- Resume after HLT continues at HLT address + 1.

## Configuration

- `CPU_SEQ_ICOUNT_EN` defined:
  - Adds output `icount` [31:0], reset 0.
  - Increments by 1 on every transition out of DECODE, EXEC, MEM or WB into FETCH or IDLE (one per retired instruction, HLT included).
  - Wraps 0xFFFFFFFF -> 0.
- Not defined: port and counter absent; all other behaviour identical.

## Test plan

- Reset, then `run` pulse, with mem[0]=NOP and mem[1]=HLT: `mem_ren` in cycles 1 and 4; `halted` returns to 1 in cycle 7; `pc`=2.
- ADD at mem[0]: `exec_stb` exactly one cycle at cycle 4, `wb_stb` at cycle 5, next FETCH at cycle 6 with `mem_addr`=1.
- LD 0x0A5 then STR 0x0B6: LD drives `mem_addr`=0x0A5 with `mem_ren`; STR drives `exec_stb`, then `mem_addr`=0x0B6 with `mem_wen`; no strobe overlap.
- BRA `cc`=0b10000 to 0x100:
  - with `psr`=0b10000: next fetch address 0x100
  - with `psr`=0b00000: next fetch address `pc`+1
  - with `cc`=0: always taken
- `pc` at 0xFFF with NOP: next fetch address 0x000. Asserting `reset` during EXEC of ADD gives no `wb_stb`, `halted`=1 and `pc`=0 the next cycle.
- With `CPU_SEQ_ICOUNT_EN`, program NOP, ADD, CMP, HLT: `icount`=4 at halt. Preload 0xFFFFFFFF, one NOP retired: `icount`=0.
